// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional saturation is selected with the BCD_SAT_EN macro.
package bcd_pkg;

    localparam int BIN_W_DEF  = 28;
    localparam int DIGITS_DEF = 8;
    localparam int DIG_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // True when every BIN_W-bit value fits in DIGITS+1 decimal digits.
    function automatic bit bcd_fits(input int bw, input int dg);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < dg + 1; i++) begin
            p = p * 128'd10;
        end
        if (bw >= 127) begin
            return 1'b0;
        end
        return (128'd1 << bw) <= p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Purely combinational; one instance per scratch digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BCD_SAT_EN to saturate to all-9s and flag overflow.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIG_W*DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int SW = DIG_W * (DIGITS + 1);
    localparam int OW = DIG_W * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    if (!bcd_fits(BIN_W, DIGITS)) begin : g_size_chk
        $error("bin2bcd_seq: 2**BIN_W exceeds 10**(DIGITS+1)");
    end

    state_e          state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SW-1:0]   scr_q, scr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   bcd_q, bcd_d;

    logic [SW-1:0]    adj;
    logic [SW-1:0]    scr_next;
    logic [BIN_W-1:0] bin_next;
    logic [OW-1:0]    res;
    logic             unused_msb;

    for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr_q[g*DIG_W +: DIG_W]),
            .dout (adj[g*DIG_W +: DIG_W])
        );
    end

    // The adjusted top digit never exceeds 7 here, so its MSB drops out.
    assign unused_msb = adj[SW-1];
    assign scr_next   = {adj[SW-2:0], bin_q[BIN_W-1]};
    assign bin_next   = {bin_q[BIN_W-2:0], 1'b0};

`ifdef BCD_SAT_EN
    logic ovf_q, ovf_d;
    logic sat;

    assign sat = |scr_next[SW-1 -: DIG_W];
    assign res = sat ? {DIGITS{4'h9}} : scr_next[OW-1:0];
`else
    assign res = scr_next[OW-1:0];
`endif

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef BCD_SAT_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    bin_d   = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                bin_d = bin_next;
                scr_d = scr_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bcd_d   = res;
`ifdef BCD_SAT_EN
                    ovf_d   = sat;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

`ifdef BCD_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq at default BIN_W=28, DIGITS=8.
// Expected values follow BCD_SAT_EN when it is defined.
module tb_bin2bcd_seq;

    localparam int BW = 28;

`ifdef BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [27:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    bin2bcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge in IDLE; returns on the negedge of cycle N+29.
    // poke>0 re-pulses start with another bin during cycle N+poke.
    task automatic run_conv(input string tag, input logic [27:0] b,
                            input logic [31:0] exp_bcd, input bit exp_ovf,
                            input bit keep, input int poke);
        int busy_err;
        int done_err;
        busy_err = 0;
        done_err = 0;
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        for (int k = 1; k <= BW + 1; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) begin
                start = 1'b0;
                bin   = 28'h5a5a5a5;
            end
            if (poke > 0 && k == poke) begin
                start = 1'b1;
                bin   = 28'd5;
            end
            if (poke > 0 && k == poke + 1) begin
                start = 1'b0;
            end
            if (busy !== (k <= BW)) busy_err++;
            if (done !== (k == BW + 1)) done_err++;
        end
        chk({tag, "_busy_win"}, busy_err, 0);
        chk({tag, "_done_win"}, done_err, 0);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        chk({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        run_conv("zero", 28'd0, 32'h00000000, 1'b0, 1'b0, 0);
        @(negedge clk);
        run_conv("mid", 28'd12345678, 32'h12345678, 1'b0, 1'b0, 0);
        @(negedge clk);
        run_conv("nines", 28'd99999999, 32'h99999999, 1'b0, 1'b0, 0);
        @(negedge clk);
        run_conv("e8", 28'd100000000,
                 SAT ? 32'h99999999 : 32'h00000000, SAT, 1'b0, 0);
        @(negedge clk);

        // Start held high: back-to-back conversions of the max value.
        run_conv("max", 28'd268435455,
                 SAT ? 32'h99999999 : 32'h68435455, SAT, 1'b1, 0);
        n = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = c;
                break;
            end
        end
        chk("b2b_gap", n, 30);
        chk("b2b_bcd", bcd, SAT ? 32'h99999999 : 32'h68435455);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start re-pulsed mid-conversion must be ignored.
        run_conv("ign", 28'd1234, 32'h00001234, 1'b0, 1'b0, 10);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("ign_extra_done", n, 0);

        // Reset in the middle of SHIFT discards the conversion.
        start = 1'b1;
        bin   = 28'd777;
        @(posedge clk);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_bcd", bcd, 0);
        chk("mrst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (35) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("mrst_quiet", n, 0);
        run_conv("after_rst", 28'd42, 32'h00000042, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
